// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline types for the fetch front end.
// Holds the fetch bundle, fetch FSM states and reset PC.
package fetch_ctrl_pkg;

  localparam logic [63:0] FETCH_RESET_PC =
    64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction bus, redirect and decode handshake
// bundle seen by the fetch sequencer.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  fetch_data_t out_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_data
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding request,
// single-entry decode buffer, redirect with stale drop.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = FETCH_RESET_PC
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  fetch_state_t state, state_n;
  logic [63:0]  pc_q, pc_n;
  logic [63:0]  req_q, req_n;
  fetch_data_t  buf_q, buf_n;
  logic [63:0]  tgt;
  logic         ok;
  logic         rdir;

  assign tgt  = bus.redirect_pc & ~64'h3;
  assign ok   = bus.iresp_data_ok;
  assign rdir = bus.redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      req_q <= '0;
      buf_q <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      req_q <= req_n;
      buf_q <= buf_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    req_n   = req_q;
    buf_n   = buf_q;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        if (rdir) begin
          pc_n  = tgt;
          req_n = tgt;
        end else begin
          req_n = pc_q;
        end
      end
      FETCH: begin
        if (ok && rdir) begin
          pc_n  = tgt;
          req_n = tgt;
        end else if (ok) begin
          buf_n   = '{raw_instr: bus.iresp_data,
                      pc:        req_q};
          pc_n    = req_q + 64'd4;
          state_n = VALID;
        end else if (rdir) begin
          pc_n    = tgt;
          state_n = DROP;
        end
      end
      DROP: begin
        // Stale request stays on the bus until it retires.
        if (ok && rdir) begin
          pc_n    = tgt;
          req_n   = tgt;
          state_n = FETCH;
        end else if (ok) begin
          req_n   = pc_q;
          state_n = FETCH;
        end else if (rdir) begin
          pc_n = tgt;
        end
      end
      VALID: begin
        if (rdir) begin
          pc_n    = tgt;
          req_n   = tgt;
          state_n = FETCH;
        end else if (bus.out_ready) begin
          req_n   = pc_q;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ireq_valid = (state == FETCH) ||
                          (state == DROP);
  assign bus.ireq_addr  = req_q;
  assign bus.out_valid  = (state == VALID);
  assign bus.out_data   = buf_q;

endmodule
